instr_prefetch_reg: RTL
=======================

INSTR_PREFETCH_REG -- requirements
Module: instr_prefetch_reg

Interface
REQ-001 SHALL have parameter IW, default 8: instruction word width.
REQ-002 SHALL have parameter OPW, default 4: opcode field width (MSBs of the word).
REQ-003 SHALL have parameter RSW, default 2: register-select field width, directly below the opcode.
REQ-004 SHALL have parameter DEPTH, default 4: prefetch entries; power of 2, >= 2.
REQ-005 SHALL have port clk, input, 1: clock; all state changes on the rising edge.
REQ-006 SHALL have port reset, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have port in_valid, input, 1: instruction_in is offered.
REQ-008 SHALL have port in_ready, output, 1: the queue accepts a word this cycle.
REQ-009 SHALL have port instruction_in, input, IW: fetched word.
REQ-010 SHALL have port flush, input, 1: discard all queued and presented words.
REQ-011 SHALL have port dec_ready, input, 1: the consumer takes the presented instruction.
REQ-012 SHALL have port dec_valid, output, 1: the decoded fields are valid.
REQ-013 SHALL have port op_code, output, OPW: word[IW-1 -: OPW].
REQ-014 SHALL have port reg_sel, output, RSW: word[IW-OPW-1 -: RSW].
REQ-015 SHALL have port data, output, IW-OPW-RSW: the remaining LSBs.
REQ-016 SHALL have port imm, output, IW: extension word (see Configuration).
REQ-017 SHALL have port count, output, clog2(DEPTH)+1: queued entries.

Function
REQ-018 SHALL push on in_valid && in_ready; in_ready = (count < DEPTH) && !flush.
REQ-019 SHALL present the head entry's fields; a word pushed in cycle N SHALL be presentable from cycle N+1, so the latency is 1.
REQ-020 SHALL assert dec_valid when count >= 1 (non-extended head); it SHALL pop one entry on dec_valid && dec_ready.
REQ-021 SHALL hold all outputs stable while dec_valid && !dec_ready.
REQ-022 SHALL allow a simultaneous push and pop when not full; count is unchanged and order is preserved.
REQ-023 SHALL refuse a push when full (in_ready low), even if a pop occurs in the same cycle; there is no pass-through.
REQ-024 SHALL use a pointer wrap at DEPTH; ordering is FIFO across the wrap.
REQ-025 SHALL, on flush, set count to 0 and drive dec_valid low in the next cycle; flush beats push and pop in the same cycle.
REQ-026 SHALL drive op_code, reg_sel, data and imm to 0 while dec_valid is low.

Reset
REQ-027 SHALL, on reset low, immediately clear pointers and count, drive dec_valid, op_code, reg_sel, data and imm to 0, and drive in_ready to 0.
REQ-028 SHALL drive in_ready high in the first cycle after reset release; any reset mid-operation discards all entries.

Configuration
REQ-029 SHALL, with IR_EXT_IMM_EN defined, treat a head opcode of all-ones as a two-word instruction whose next entry is imm.
REQ-030 SHALL, with IR_EXT_IMM_EN, hold dec_valid low while an extended head has count < 2, and SHALL pop two entries on handshake.
REQ-031 SHALL, with IR_EXT_IMM_EN, discard an incomplete pair on flush.
REQ-032 SHALL, without IR_EXT_IMM_EN, tie imm to 0 and treat every word, including opcode all-ones, as a single instruction.

Structure
REQ-033 SHALL take default IW/OPW/RSW and the EXT_OPCODE constant (all ones) from the shared package cpu_ir_pkg.
REQ-034 SHALL place the storage and pointers in sub-module ir_fifo (sync FIFO, DEPTH x IW, exposes two head entries); decode and handshake stay in the top level.

Verification
REQ-035 SHALL cover: reset, push 0x5B, dec_ready=1 -> next cycle dec_valid=1, op_code=5, reg_sel=2, data=3; popped, count=0.
REQ-036 SHALL cover: push 4 words with dec_ready=0 -> count=4, in_ready=0; a 5th offer is not accepted and outputs are held.
REQ-037 SHALL cover: full with simultaneous push and pop -> push refused; at count=2, push and pop -> count stays 2, order is intact.
REQ-038 SHALL cover: flush together with in_valid at count=3 -> count=0, dec_valid=0, and the word is not stored.
REQ-039 SHALL cover, with IR_EXT_IMM_EN: push 0xF1, wait, push 0xA5 -> dec_valid low until both are present, then op_code=F, imm=0xA5, and count drops by 2.
REQ-040 SHALL cover: reset asserted at count=2 -> outputs 0 asynchronously; after release count=0 and in_ready=1.

Source files
------------

// File: rtl/cpu_ir_pkg.sv
// Shared instruction-register constants: default field widths and the
// opcode value that marks a two-word (immediate-extended) instruction.
package cpu_ir_pkg;

    localparam int IW_DEFAULT  = 8;
    localparam int OPW_DEFAULT = 4;
    localparam int RSW_DEFAULT = 2;

    // All-ones opcode at the default opcode width.
    localparam logic [OPW_DEFAULT-1:0] EXT_OPCODE = '1;

endpackage

// File: rtl/ir_fifo.sv
// Synchronous prefetch FIFO, DEPTH x IW, with an asynchronous active-low
// reset. Exposes the two oldest entries so the decoder can see an
// instruction word and its immediate at the same time. It can pop one or
// two entries per cycle. Flush empties the queue and overrides push/pop.
module ir_fifo #(
    parameter int IW    = 8,
    parameter int DEPTH = 4,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          push,
    input  logic [IW-1:0] push_data,
    input  logic          pop,
    input  logic          pop_two,
    output logic [IW-1:0] head0,
    output logic [IW-1:0] head1,
    output logic [CW-1:0] count
);

    logic [IW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;
    logic [PW-1:0] rd_step;
    logic [PW-1:0] rd_ptr_plus1;

    // Pop advances the read side by one or two entries.
    // The pointer width wraps naturally because DEPTH is a power of two.
    always_comb begin
        rd_step      = pop_two ? PW'(2) : PW'(1);
        rd_ptr_plus1 = rd_ptr_reg + PW'(1);
        count_next   = count_reg;
        if (push) begin
            count_next = count_next + CW'(1);
        end
        if (pop) begin
            count_next = count_next - (pop_two ? CW'(2) : CW'(1));
        end
    end

    // Storage write; the array holds no reset, and only the pointers give it meaning.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // Pointer and occupancy registers; flush and reset both empty the queue.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + rd_step;
            end
            count_reg <= count_next;
        end
    end

    assign head0 = mem[rd_ptr_reg];
    assign head1 = mem[rd_ptr_plus1];
    assign count = count_reg;

endmodule

// File: rtl/instr_prefetch_reg.sv
// Instruction prefetch register: queues fetched words and presents the
// oldest one split into opcode / register-select / data fields.
// Optional macro IR_EXT_IMM_EN: an all-ones opcode makes the head a
// two-word instruction whose following entry is presented on imm.
// Without the macro, imm is 0 and every word is a single instruction.
module instr_prefetch_reg
    import cpu_ir_pkg::*;
#(
    parameter int IW    = IW_DEFAULT,
    parameter int OPW   = OPW_DEFAULT,
    parameter int RSW   = RSW_DEFAULT,
    parameter int DEPTH = 4,
    localparam int DW   = IW - OPW - RSW,
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [IW-1:0]  instruction_in,
    input  logic           flush,
    input  logic           dec_ready,
    output logic           dec_valid,
    output logic [OPW-1:0] op_code,
    output logic [RSW-1:0] reg_sel,
    output logic [DW-1:0]  data,
    output logic [IW-1:0]  imm,
    output logic [CW-1:0]  count
);

    logic [IW-1:0] head_word;
    logic [IW-1:0] next_word;
    logic [CW-1:0] fifo_count;
    logic          push;
    logic          pop;
    logic          head_ext;

`ifdef IR_EXT_IMM_EN
    // Match the package constant when widths agree, otherwise all ones at OPW.
    localparam logic [OPW-1:0] EXT_OP =
        (OPW == OPW_DEFAULT) ? OPW'(EXT_OPCODE) : {OPW{1'b1}};
    assign head_ext = (head_word[IW-1 -: OPW] == EXT_OP);
`else
    logic unused_next_word;
    assign unused_next_word = ^next_word;
    assign head_ext = 1'b0;
`endif

    // Handshakes and decode; fields are forced to zero whenever nothing is presented.
    always_comb begin
        in_ready  = reset && (fifo_count < CW'(DEPTH)) && !flush;
        push      = in_valid && in_ready;
        dec_valid = head_ext ? (fifo_count >= CW'(2)) : (fifo_count >= CW'(1));
        pop       = dec_valid && dec_ready && !flush;
        op_code   = '0;
        reg_sel   = '0;
        data      = '0;
        imm       = '0;
        if (dec_valid) begin
            op_code = head_word[IW-1 -: OPW];
            reg_sel = head_word[IW-OPW-1 -: RSW];
            data    = head_word[DW-1:0];
            if (head_ext) begin
                imm = next_word;
            end
        end
    end

    ir_fifo #(
        .IW    (IW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .push      (push),
        .push_data (instruction_in),
        .pop       (pop),
        .pop_two   (head_ext),
        .head0     (head_word),
        .head1     (next_word),
        .count     (fifo_count)
    );

    assign count = fifo_count;

endmodule
